// File: rtl/hazard_unit_pkg.sv
// Shared defaults and state encoding for the hazard unit.
// Optional load-use stalling is selected by LOAD_USE_STALL_EN.
package hazard_unit_pkg;

    localparam int unsigned HZ_CONTROL_SIZE = 10;
    localparam int unsigned HZ_REG_W        = 5;
    localparam int unsigned HZ_WAIT_MAX     = 3;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_CTRL_WAIT = 2'd1
    } hz_state_e;

endpackage

// File: rtl/hazard_unit_load_use_cmp.sv
// Load-use comparator: an EX load whose non-zero destination feeds an ID source.
// Only present when LOAD_USE_STALL_EN is defined.
`ifdef LOAD_USE_STALL_EN
module hazard_load_use_cmp
    import hazard_unit_pkg::*;
#(
    parameter int unsigned REG_W = HZ_REG_W
) (
    input  logic             i_ex_mem_read,
    input  logic [REG_W-1:0] i_ex_rt,
    input  logic [REG_W-1:0] i_id_rs,
    input  logic [REG_W-1:0] i_id_rt,
    output logic             o_load_use
);

    assign o_load_use = i_ex_mem_read && (i_ex_rt != '0) &&
                        ((i_ex_rt == i_id_rs) || (i_ex_rt == i_id_rt));

endmodule
`endif

// File: rtl/hazard_unit.sv
// Pipeline hazard unit: load-use stall and control-hazard wait with timeout.
// Define LOAD_USE_STALL_EN to enable load-use stalling; otherwise loads never stall.
module hazard_unit
    import hazard_unit_pkg::*;
#(
    parameter int unsigned CONTROL_SIZE = HZ_CONTROL_SIZE,
    parameter int unsigned REG_W        = HZ_REG_W,
    parameter int unsigned WAIT_MAX     = HZ_WAIT_MAX
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    isJump,
    input  logic [REG_W-1:0]        idRs,
    input  logic [REG_W-1:0]        idRt,
    input  logic                    exMemRead,
    input  logic [REG_W-1:0]        exRt,
    input  logic                    resolveValid,
    input  logic                    resolveTaken,
    input  logic [CONTROL_SIZE-1:0] controlIn,
    output logic [CONTROL_SIZE-1:0] controlOut,
    output logic                    pcWrite,
    output logic                    ifIdWrite,
    output logic                    ifIdFlush,
    output logic                    waitTimeout,
    output logic [1:0]              hazardState
);

    localparam int unsigned CNT_W = $clog2(WAIT_MAX + 1);

    hz_state_e        r_state;
    hz_state_e        w_state_nxt;
    logic [CNT_W-1:0] r_wait_cnt;
    logic [CNT_W-1:0] w_wait_cnt_nxt;
    logic             r_timeout;
    logic             w_timeout_set;
    logic             w_load_use;
    logic             w_unused;

    // resolveTaken only steers the external PC mux.
`ifdef LOAD_USE_STALL_EN
    hazard_load_use_cmp #(
        .REG_W (REG_W)
    ) u_load_use_cmp (
        .i_ex_mem_read (exMemRead),
        .i_ex_rt       (exRt),
        .i_id_rs       (idRs),
        .i_id_rt       (idRt),
        .o_load_use    (w_load_use)
    );
    assign w_unused = resolveTaken;
`else
    assign w_load_use = 1'b0;
    assign w_unused   = ^{resolveTaken, exMemRead, exRt, idRs, idRt};
`endif

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state    <= ST_IDLE;
            r_wait_cnt <= '0;
            r_timeout  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_wait_cnt <= w_wait_cnt_nxt;
            r_timeout  <= r_timeout | w_timeout_set;
        end
    end

    always_comb begin
        w_state_nxt    = ST_IDLE;
        w_wait_cnt_nxt = r_wait_cnt;
        w_timeout_set  = 1'b0;
        controlOut     = '0;
        pcWrite        = 1'b0;
        ifIdWrite      = 1'b0;
        ifIdFlush      = 1'b0;

        if (reset) begin
            unique case (r_state)
                ST_IDLE: begin
                    if (w_load_use) begin
                        w_state_nxt = ST_IDLE;
                    end else if (isJump) begin
                        controlOut     = controlIn;
                        ifIdFlush      = 1'b1;
                        w_wait_cnt_nxt = '0;
                        w_state_nxt    = ST_CTRL_WAIT;
                    end else begin
                        controlOut = controlIn;
                        pcWrite    = 1'b1;
                        ifIdWrite  = 1'b1;
                    end
                end
                ST_CTRL_WAIT: begin
                    if (resolveValid) begin
                        pcWrite = 1'b1;
                    end else if (r_wait_cnt == CNT_W'(WAIT_MAX - 1)) begin
                        pcWrite       = 1'b1;
                        w_timeout_set = 1'b1;
                    end else begin
                        // Saturating so the counter can never wrap.
                        if (r_wait_cnt < CNT_W'(WAIT_MAX)) begin
                            w_wait_cnt_nxt = r_wait_cnt + CNT_W'(1);
                        end
                        w_state_nxt = ST_CTRL_WAIT;
                    end
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    assign waitTimeout = r_timeout;
    assign hazardState = reset ? 2'(r_state) : 2'b00;

endmodule

// File: tb/tb_hazard_unit.sv
// Randomized scoreboard bench for hazard_unit against a cycle-level behavioural model.
// Honors LOAD_USE_STALL_EN the same way as the design.
module tb_hazard_unit;
    import hazard_unit_pkg::*;

    localparam int unsigned CS = HZ_CONTROL_SIZE;
    localparam int unsigned RW = HZ_REG_W;
    localparam int unsigned WM = HZ_WAIT_MAX;

    typedef struct packed {
        logic [CS-1:0] ctrl;
        logic          pc;
        logic          ifw;
        logic          flush;
        logic          tmo;
        logic [1:0]    st;
    } exp_t;

    logic          clock;
    logic          reset;
    logic          isJump;
    logic [RW-1:0] idRs;
    logic [RW-1:0] idRt;
    logic          exMemRead;
    logic [RW-1:0] exRt;
    logic          resolveValid;
    logic          resolveTaken;
    logic [CS-1:0] controlIn;
    logic [CS-1:0] controlOut;
    logic          pcWrite;
    logic          ifIdWrite;
    logic          ifIdFlush;
    logic          waitTimeout;
    logic [1:0]    hazardState;

    hazard_unit dut (
        .clock        (clock),
        .reset        (reset),
        .isJump       (isJump),
        .idRs         (idRs),
        .idRt         (idRt),
        .exMemRead    (exMemRead),
        .exRt         (exRt),
        .resolveValid (resolveValid),
        .resolveTaken (resolveTaken),
        .controlIn    (controlIn),
        .controlOut   (controlOut),
        .pcWrite      (pcWrite),
        .ifIdWrite    (ifIdWrite),
        .ifIdFlush    (ifIdFlush),
        .waitTimeout  (waitTimeout),
        .hazardState  (hazardState)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    exp_t q_exp[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc   = 0;

    // Behavioural model: are we waiting on a branch, how many wait cycles so far, error latched.
    bit m_in_wait = 1'b0;
    int m_waits   = 0;
    bit m_tflag   = 1'b0;

    task automatic chk(input string name, input int c, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s cycle %0d: got 0x%0h, expected 0x%0h", name, c, act, req);
        end
    endtask

    task automatic step(input bit rst, input bit jmp, input int rs, input int rt,
                        input bit mr, input int ert, input bit rv, input bit rtk,
                        input int ci);
        exp_t e;
        bit   lu;
        @(posedge clock);
        #1;
        reset        = rst;
        isJump       = jmp;
        idRs         = RW'(rs);
        idRt         = RW'(rt);
        exMemRead    = mr;
        exRt         = RW'(ert);
        resolveValid = rv;
        resolveTaken = rtk;
        controlIn    = CS'(ci);

        e     = '0;
        e.tmo = m_tflag;
        lu    = 1'b0;
`ifdef LOAD_USE_STALL_EN
        lu = mr && (ert != 0) && (ert == rs || ert == rt);
`endif
        if (!rst) begin
            m_in_wait = 1'b0;
            m_waits   = 0;
            m_tflag   = 1'b0;
        end else if (!m_in_wait) begin
            if (!lu) begin
                e.ctrl = CS'(ci);
                if (jmp) begin
                    e.flush   = 1'b1;
                    m_in_wait = 1'b1;
                    m_waits   = 0;
                end else begin
                    e.pc  = 1'b1;
                    e.ifw = 1'b1;
                end
            end
        end else begin
            e.st    = 2'd1;
            m_waits = m_waits + 1;
            if (rv) begin
                e.pc      = 1'b1;
                m_in_wait = 1'b0;
            end else if (m_waits == int'(WM)) begin
                e.pc      = 1'b1;
                m_tflag   = 1'b1;
                m_in_wait = 1'b0;
            end
        end
        q_exp.push_back(e);
    endtask

    // Monitor: outputs are valid every cycle; pop one expectation per driven cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (q_exp.size() > 0) begin
                e = q_exp.pop_front();
                cyc++;
                chk("controlOut",  cyc, 32'(controlOut),  32'(e.ctrl));
                chk("pcWrite",     cyc, 32'(pcWrite),     32'(e.pc));
                chk("ifIdWrite",   cyc, 32'(ifIdWrite),   32'(e.ifw));
                chk("ifIdFlush",   cyc, 32'(ifIdFlush),   32'(e.flush));
                chk("waitTimeout", cyc, 32'(waitTimeout), 32'(e.tmo));
                chk("hazardState", cyc, 32'(hazardState), 32'(e.st));
            end
        end
    end

    initial begin
        reset = 1'b0; isJump = 1'b0; idRs = '0; idRt = '0; exMemRead = 1'b0;
        exRt = '0; resolveValid = 1'b0; resolveTaken = 1'b0; controlIn = '0;

        step(0, 0, 0, 0, 0, 0, 0, 0, 'h155);
        step(0, 1, 8, 0, 1, 8, 1, 1, 'h3ff);
        // load-use hit, then clear
        step(1, 0, 8, 3, 1, 8, 0, 0, 'h0aa);
        step(1, 0, 8, 3, 0, 8, 0, 0, 'h0ab);
        // r0 destination never stalls
        step(1, 0, 0, 0, 1, 0, 0, 0, 'h0cc);
        // jump, resolved on second wait cycle
        step(1, 1, 1, 2, 0, 0, 0, 0, 'h021);
        step(1, 1, 1, 2, 0, 0, 0, 0, 'h111);
        step(1, 0, 1, 2, 0, 0, 1, 1, 'h112);
        step(1, 0, 1, 2, 0, 0, 0, 0, 'h113);
        // resolveValid ignored in IDLE
        step(1, 0, 1, 2, 0, 0, 1, 0, 'h114);
        // jump with timeout, then sticky flag
        step(1, 1, 4, 5, 0, 0, 0, 0, 'h200);
        step(1, 1, 4, 5, 1, 4, 0, 0, 'h201);
        step(1, 0, 4, 5, 0, 0, 0, 0, 'h202);
        step(1, 0, 4, 5, 0, 0, 0, 0, 'h203);
        for (int i = 0; i < 4; i++) step(1, 0, 1, 1, 0, 0, 0, 0, 'h010 + i);
        // load-use plus jump together
        step(1, 1, 6, 7, 1, 7, 0, 0, 'h300);
        step(1, 1, 6, 7, 0, 7, 0, 0, 'h301);
        step(1, 0, 6, 7, 0, 7, 1, 0, 'h302);
        // reset during wait
        step(1, 1, 0, 0, 0, 0, 0, 0, 'h044);
        step(0, 0, 0, 0, 0, 0, 0, 0, 'h045);
        step(1, 0, 0, 0, 0, 0, 0, 0, 'h046);

        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 63) != 0, $urandom_range(0, 3) == 0,
                 int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                 $urandom_range(0, 1) == 1, int'($urandom_range(0, 3)),
                 $urandom_range(0, 4) == 0, $urandom_range(0, 1) == 1,
                 int'($urandom_range(0, 1023)));
        end

        repeat (3) @(negedge clock);
        chk("scoreboard_drain", cyc, 32'(q_exp.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
